// File: rtl/ccff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ccff_pkg                                                  |
// | Brief    : Shared types and helpers for the config-chain shadow      |
// |            memory (load state, size limit, counter width).           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package ccff_pkg;

    // Upper bound on select bits a single chain element can drive.
    localparam int CCFF_MAX_BITS = 32;

    // Load progress of the shift register between commits.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_LOADED  = 2'd2
    } ccff_state_e;

    // Plain encoded forms of the same states for legacy comparisons.
    localparam logic [1:0] c_ST_EMPTY   = 2'd0;
    localparam logic [1:0] c_ST_PARTIAL = 2'd1;
    localparam logic [1:0] c_ST_LOADED  = 2'd2;

    // Width needed to count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : ccff_pkg
`default_nettype wire

// File: rtl/ccff_dff_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ccff_dff_cell                                             |
// | Brief    : Single flop with enable and asynchronous active-low       |
// |            reset; building block of the chain and shadow stages.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ccff_dff_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    // Capture i_d when enabled; reset forces the per-bit reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule : ccff_dff_cell
`default_nettype wire

// File: rtl/ccff_shadow_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ccff_shadow_mem                                           |
// | Brief    : Serial config shift chain with a shadow register that     |
// |            updates mux selects only on a checked commit.             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ccff_shadow_mem
    import ccff_pkg::*;
#(
    parameter int                  CFG_BITS  = 6,
    parameter logic [CFG_BITS-1:0] RESET_VAL = {CFG_BITS{1'b0}}
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                ccff_commit,
    output logic                ccff_tail,
    output logic [CFG_BITS-1:0] mem_out,
    output logic [CFG_BITS-1:0] mem_outb,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int            c_CW   = cnt_width(CFG_BITS);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(CFG_BITS);

    logic [CFG_BITS-1:0] w_sh;
    logic [CFG_BITS-1:0] w_mem;
    logic [c_CW-1:0]     r_cnt;
    logic [c_CW-1:0]     w_cnt_next;
    logic [1:0]          w_state;
    logic                w_commit_ok;
    logic                r_cfg_valid;
    logic                r_cfg_err;

    // Shift chain: bit 0 takes the head, each bit takes its lower neighbour.
    generate
        for (genvar i = 0; i < CFG_BITS; i++) begin : g_chain
            logic w_d;
            if (i == 0) begin : g_head
                assign w_d = ccff_head;
            end else begin : g_link
                assign w_d = w_sh[i-1];
            end
            ccff_dff_cell #(.RST_VAL(1'b0)) u_sh (
                .clk   (prog_clk),
                .rst_n (prog_reset_n),
                .i_en  (ccff_en),
                .i_d   (w_d),
                .o_q   (w_sh[i])
            );
        end
    endgenerate

    // Shadow stage: loads the pre-shift chain contents on a good commit.
    generate
        for (genvar i = 0; i < CFG_BITS; i++) begin : g_shadow
            ccff_dff_cell #(.RST_VAL(RESET_VAL[i])) u_mem (
                .clk   (prog_clk),
                .rst_n (prog_reset_n),
                .i_en  (w_commit_ok),
                .i_d   (w_sh[i]),
                .o_q   (w_mem[i])
            );
        end
    endgenerate

    // Load state is a pure decode of the shift count.
    always_comb begin
        w_state = c_ST_EMPTY;
        if (r_cnt == c_FULL) begin
            w_state = c_ST_LOADED;
        end else if (r_cnt != '0) begin
            w_state = c_ST_PARTIAL;
        end
    end

    assign w_commit_ok = ccff_commit && (w_state == c_ST_LOADED);

    // Next count: commit restarts it (counting a same-cycle shift), shifts saturate.
    always_comb begin
        w_cnt_next = r_cnt;
        if (ccff_commit) begin
            w_cnt_next = ccff_en ? c_CW'(1) : '0;
        end else if (ccff_en && (r_cnt != c_FULL)) begin
            w_cnt_next = r_cnt + c_CW'(1);
        end
    end

    // Count and status flags; error is sticky until the next good commit.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_cnt       <= '0;
            r_cfg_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_commit_ok) begin
                r_cfg_valid <= 1'b1;
                r_cfg_err   <= 1'b0;
            end else if (ccff_commit) begin
                r_cfg_err   <= 1'b1;
            end
        end
    end

    assign ccff_tail = w_sh[CFG_BITS-1];
    assign mem_out   = w_mem;
    assign mem_outb  = ~w_mem;
    assign cfg_valid = r_cfg_valid;
    assign cfg_err   = r_cfg_err;

endmodule : ccff_shadow_mem
`default_nettype wire

// File: tb/tb_ccff_shadow_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ccff_shadow_mem                                        |
// | Brief    : Directed, table-driven self-checking bench for            |
// |            ccff_shadow_mem (CFG_BITS=6, RESET_VAL=0).                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ccff_shadow_mem;

    typedef struct {
        logic       en;
        logic       head;
        logic       commit;
        logic [5:0] exp_mem;
        logic       exp_tail;
        logic       exp_valid;
        logic       exp_err;
    } vec_t;

    logic       prog_clk;
    logic       prog_reset_n;
    logic       ccff_head;
    logic       ccff_en;
    logic       ccff_commit;
    logic       ccff_tail;
    logic [5:0] mem_out;
    logic [5:0] mem_outb;
    logic       cfg_valid;
    logic       cfg_err;

    int n_cmp;
    int n_bad;
    vec_t vq[$];

    ccff_shadow_mem #(
        .CFG_BITS  (6),
        .RESET_VAL (6'b000000)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .ccff_head    (ccff_head),
        .ccff_en      (ccff_en),
        .ccff_commit  (ccff_commit),
        .ccff_tail    (ccff_tail),
        .mem_out      (mem_out),
        .mem_outb     (mem_outb),
        .cfg_valid    (cfg_valid),
        .cfg_err      (cfg_err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] m, input logic t,
                           input logic v, input logic e);
        chk({tag, " mem_out"},   {26'd0, mem_out},  {26'd0, m});
        chk({tag, " mem_outb"},  {26'd0, mem_outb}, {26'd0, ~m});
        chk({tag, " ccff_tail"}, {31'd0, ccff_tail}, {31'd0, t});
        chk({tag, " cfg_valid"}, {31'd0, cfg_valid}, {31'd0, v});
        chk({tag, " cfg_err"},   {31'd0, cfg_err},  {31'd0, e});
    endtask

    // Drive inputs on the falling edge, sample just after the rising edge.
    task automatic step(input logic en, input logic head, input logic commit);
        @(negedge prog_clk);
        ccff_en     = en;
        ccff_head   = head;
        ccff_commit = commit;
        @(posedge prog_clk);
        #1;
    endtask

    task automatic add(input logic en, input logic head, input logic commit,
                       input logic [5:0] m, input logic t, input logic v, input logic e);
        vec_t r;
        r.en = en; r.head = head; r.commit = commit;
        r.exp_mem = m; r.exp_tail = t; r.exp_valid = v; r.exp_err = e;
        vq.push_back(r);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        prog_reset_n = 1'b0;
        ccff_head    = 1'b0;
        ccff_en      = 1'b0;
        ccff_commit  = 1'b0;

        // Full load 1,0,1,1,0,1 then commit
        add(1,1,0, 6'b000000, 0, 0, 0);
        add(1,0,0, 6'b000000, 0, 0, 0);
        add(1,1,0, 6'b000000, 0, 0, 0);
        add(1,1,0, 6'b000000, 0, 0, 0);
        add(1,0,0, 6'b000000, 0, 0, 0);
        add(1,1,0, 6'b000000, 1, 0, 0);
        add(0,0,1, 6'b101101, 1, 1, 0);
        // Short commit after 4 shifts, then full reload
        add(1,0,0, 6'b101101, 0, 1, 0);
        add(1,1,0, 6'b101101, 1, 1, 0);
        add(1,1,0, 6'b101101, 1, 1, 0);
        add(1,0,0, 6'b101101, 0, 1, 0);
        add(0,0,1, 6'b101101, 0, 1, 1);
        add(1,0,0, 6'b101101, 1, 1, 1);
        add(1,1,0, 6'b101101, 0, 1, 1);
        add(1,1,0, 6'b101101, 1, 1, 1);
        add(1,1,0, 6'b101101, 1, 1, 1);
        add(1,0,0, 6'b101101, 0, 1, 1);
        add(1,0,0, 6'b101101, 0, 1, 1);
        add(0,0,1, 6'b011100, 0, 1, 0);
        // Overshift 1,1,1,0,0,0,1,0,1
        add(1,1,0, 6'b011100, 1, 1, 0);
        add(1,1,0, 6'b011100, 1, 1, 0);
        add(1,1,0, 6'b011100, 1, 1, 0);
        add(1,0,0, 6'b011100, 0, 1, 0);
        add(1,0,0, 6'b011100, 0, 1, 0);
        add(1,0,0, 6'b011100, 1, 1, 0);
        add(1,1,0, 6'b011100, 1, 1, 0);
        add(1,0,0, 6'b011100, 1, 1, 0);
        add(1,1,0, 6'b011100, 0, 1, 0);
        add(0,0,1, 6'b000101, 0, 1, 0);
        // Load 110011, simultaneous shift+commit, then repeated commit errors
        add(1,1,0, 6'b000101, 0, 1, 0);
        add(1,1,0, 6'b000101, 0, 1, 0);
        add(1,0,0, 6'b000101, 1, 1, 0);
        add(1,0,0, 6'b000101, 0, 1, 0);
        add(1,1,0, 6'b000101, 1, 1, 0);
        add(1,1,0, 6'b000101, 1, 1, 0);
        add(1,0,1, 6'b110011, 1, 1, 0);
        add(0,0,1, 6'b110011, 1, 1, 1);
        // Reload 101010; simultaneous event leaves cnt=1, so 5 more shifts suffice
        add(1,1,0, 6'b110011, 0, 1, 1);
        add(1,0,0, 6'b110011, 0, 1, 1);
        add(1,1,0, 6'b110011, 1, 1, 1);
        add(1,0,0, 6'b110011, 1, 1, 1);
        add(1,1,0, 6'b110011, 0, 1, 1);
        add(1,0,0, 6'b110011, 1, 1, 1);
        add(1,1,1, 6'b101010, 0, 1, 0);
        add(1,1,0, 6'b101010, 1, 1, 0);
        add(1,1,0, 6'b101010, 0, 1, 0);
        add(1,1,0, 6'b101010, 1, 1, 0);
        add(1,1,0, 6'b101010, 0, 1, 0);
        add(1,1,0, 6'b101010, 1, 1, 0);
        add(0,0,1, 6'b111111, 1, 1, 0);
        // Idle holds everything
        add(0,1,0, 6'b111111, 1, 1, 0);
        add(0,0,0, 6'b111111, 1, 1, 0);

        // Reset state
        repeat (2) @(posedge prog_clk);
        #1;
        chk_all("reset", 6'b000000, 1'b0, 1'b0, 1'b0);
        @(negedge prog_clk);
        prog_reset_n = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].en, vq[i].head, vq[i].commit);
            chk_all($sformatf("vec%0d", i), vq[i].exp_mem, vq[i].exp_tail,
                    vq[i].exp_valid, vq[i].exp_err);
        end

        // Async reset between clock edges after 3 shifts
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        chk_all("pre_areset", 6'b111111, 1'b1, 1'b1, 1'b0);
        #2;
        prog_reset_n = 1'b0;
        #1;
        chk_all("areset", 6'b000000, 1'b0, 1'b0, 1'b0);
        @(negedge prog_clk);
        prog_reset_n = 1'b1;

        // Normal load 0,0,1,0,1,1 after reset
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        chk_all("post_load", 6'b000000, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1);
        chk_all("post_commit", 6'b001011, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ccff_shadow_mem
`default_nettype wire

// File: doc/ccff_shadow_mem.md
Name: ccff_shadow_mem

Overview:
- Configuration-memory stage directly upstream of the routing mux trees (e.g. the 45-input, 6-select tap-buffered mux). It drives their `sram`/`sram_inv` pairs.
- Config bits arrive serially on the programming scan chain (`ccff_head` → `ccff_tail`) and collect in a shift register.
- They reach the mux selects only on an explicit commit. This keeps the mux selects glitch-free while downstream chain segments are still shifting.
- Commit checks that enough bits were shifted and reports a sticky error otherwise.

Parameters:
- CFG_BITS, 6, number of select bits driven (equals the mux `sram` width); legal range 1..32.
- RESET_VAL, {CFG_BITS{1'b0}}, value of `mem_out` after reset.

Ports:
- prog_clk  in  1  programming clock; all state is on its rising edge.
- prog_reset_n  in  1  asynchronous, active-low reset; asserts immediately, deassertion is synchronised externally.
- ccff_head  in  1  serial config data from the previous chain element.
- ccff_en  in  1  shift enable; one bit shifted per prog_clk while high.
- ccff_commit  in  1  single-cycle pulse that transfers the shift register to the outputs.
- ccff_tail  out  1  serial data to the next chain element (= sh[CFG_BITS-1]).
- mem_out  out  CFG_BITS  committed select bits, to mux `sram`.
- mem_outb  out  CFG_BITS  bitwise complement of `mem_out`, to mux `sram_inv`.
- cfg_valid  out  1  high once at least one successful commit has occurred since reset.
- cfg_err  out  1  sticky: a commit was attempted with fewer than CFG_BITS shifts.

Behaviour:
- Reset (prog_reset_n=0, async) sets:
  - sh=0 and ccff_tail=0
  - cnt=0 and state=EMPTY
  - mem_out=RESET_VAL and mem_outb=~RESET_VAL
  - cfg_valid=0 and cfg_err=0
- Reset asserted mid-shift discards all partial data. Outputs return to reset values in the same instant.
- Shift (ccff_en=1): sh[0]<=ccff_head and sh[i]<=sh[i-1]. The first bit shifted ends in sh[CFG_BITS-1]. ccff_tail is the register output, so there is one cycle of latency per element and no combinational head→tail path.
- Counter cnt, width $clog2(CFG_BITS+1), increments per shift and saturates at CFG_BITS. Extra shifts pass through to the tail; the last CFG_BITS bits are retained.
- State machine, with the state derived from cnt:
  - EMPTY (cnt=0) → PARTIAL on a shift.
  - PARTIAL (0<cnt<CFG_BITS) → LOADED when cnt reaches CFG_BITS.
  - LOADED stays LOADED on further shifts.
  - Any state → EMPTY on commit.
  - For CFG_BITS=1, EMPTY goes directly to LOADED.
- Commit in LOADED:
  - mem_out<=sh and mem_outb<=~sh on the next edge (latency 1).
  - cfg_valid<=1, cfg_err<=0, cnt<=0.
- Commit in EMPTY or PARTIAL:
  - mem_out, mem_outb and cfg_valid are unchanged.
  - cfg_err<=1 and cnt<=0. sh is retained.
- Simultaneous ccff_en and ccff_commit:
  - Commit uses the pre-shift sh value.
  - The shift still occurs.
  - cnt becomes 1 (state PARTIAL).
- mem_out/mem_outb change only on a successful commit or reset, never during shifting. mem_outb is always the exact complement of mem_out.
- ccff_commit held high for several cycles counts as successive commits. The second one sees cnt=0 or 1 and sets cfg_err. Callers pulse for one cycle.
- Idle (ccff_en=0, ccff_commit=0): all state holds.

Decomposition:
- Shared package `ccff_pkg`:
  - state enum {EMPTY, PARTIAL, LOADED}
  - CCFF_MAX_BITS=32
  - function cnt_width(n) returning $clog2(n+1)
- One natural sub-module, `ccff_dff_cell`: a single async-active-low-reset flop with enable.
  - Instantiated CFG_BITS times for the shift chain.
  - Instantiated CFG_BITS times for the shadow stage (reset value taken per bit from RESET_VAL).

Test Plan:
1. Reset check: after reset with CFG_BITS=6, RESET_VAL=0 → mem_out=6'b000000, mem_outb=6'b111111, ccff_tail=0, cfg_valid=0, cfg_err=0.
2. Full load: shift 1,0,1,1,0,1 (6 cycles) then commit.
   - During the shifts, mem_out stays 0.
   - One cycle after commit: mem_out=6'b101101, mem_outb=6'b010010, cfg_valid=1.
3. Short commit: shift 4 bits then commit → cfg_err=1 and mem_out unchanged. Then shift 6 bits and commit → cfg_err=0 and new value applied.
4. Overshift: shift 9 bits 1,1,1,0,0,0,1,0,1 → ccff_tail outputs the first 3 bits (1,1,1) on cycles 7..9. Commit → mem_out=6'b000101.
5. Simultaneous events: with 6 bits 110011 loaded, assert ccff_en=1 (head=0) and ccff_commit=1 together → mem_out=6'b110011 and cnt=1. A commit in the next cycle sets cfg_err=1.
6. Reset mid-operation: after 3 shifts, pulse prog_reset_n low between clock edges → outputs go to reset values immediately (asynchronous). A subsequent 6-bit load and commit works normally.
